// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter sequencing with stall buffering of redirects.
// Optional misaligned-target fault checking is enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             I_BUSYWAIT,
    input  logic             D_BUSYWAIT,
    input  logic             JUMP,
    input  logic             BRANCH,
    input  logic             ZERO,
    input  logic [31:0]      OFFSET,
    output logic [31:0]      PC,
    output logic             FETCH_VALID,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic             MISALIGN
);
    localparam logic [1:0] RUN   = 2'b00;
    localparam logic [1:0] STALL = 2'b01;
    localparam logic [1:0] FAULT = 2'b10;

    logic [1:0]       r_state, w_next_state;
    logic [31:0]      r_pc, r_pend_target, w_pc_plus4, w_raw_target, w_target;
    logic             r_pend_valid, r_misalign;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_stall, w_taken, w_bad_run, w_bad_rel;
    logic             w_run_go, w_run_hold, w_release;

    assign w_stall      = I_BUSYWAIT | D_BUSYWAIT;
    assign w_taken      = JUMP | (BRANCH & ZERO);
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_raw_target = w_pc_plus4 + OFFSET;
    assign w_run_go     = (r_state == RUN) && !w_stall;
    assign w_run_hold   = (r_state == RUN) && w_stall;
    assign w_release    = (r_state == STALL) && !w_stall;
`ifdef PC_ALIGN_CHECK_EN
    assign w_target  = w_raw_target;
    assign w_bad_run = w_taken && (w_target[1:0] != 2'b00);
    assign w_bad_rel = r_pend_valid && (r_pend_target[1:0] != 2'b00);
`else
    assign w_target  = w_raw_target & ~32'd3;
    assign w_bad_run = 1'b0;
    assign w_bad_rel = 1'b0;
`endif

    // State register; reset forces RUN
    always_ff @(posedge CLK) begin
        r_state <= RESET ? RUN : w_next_state;
    end

    // Next-state decision; the unused encoding falls back to RUN
    always_comb begin
        w_next_state = (r_state == FAULT) ? FAULT :
                       (r_state == RUN)   ? (w_stall ? STALL : (w_bad_run ? FAULT : RUN)) :
                       (r_state == STALL) ? (w_stall ? STALL : (w_bad_rel ? FAULT : RUN)) :
                       RUN;
    end

    // Outputs: fetch advances only in RUN without a stall, never during reset
    always_comb begin
        FETCH_VALID = !RESET && w_run_go;
        PC          = r_pc;
        STALL_CNT   = r_stall_cnt;
        MISALIGN    = r_misalign;
    end

    // PC and pending-redirect datapath; the redirect is captured only on the RUN->STALL edge
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pc          <= RESET_VECTOR;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'd0;
        end else if (w_run_go) begin
            if (!w_bad_run) r_pc <= w_taken ? w_target : w_pc_plus4;
        end else if (w_run_hold) begin
            if (w_taken) begin
                r_pend_target <= w_target;
                r_pend_valid  <= 1'b1;
            end
        end else if (w_release) begin
            if (!w_bad_rel) r_pc <= r_pend_valid ? r_pend_target : w_pc_plus4;
            r_pend_valid <= 1'b0;
        end
    end

    // Saturating count of stalled cycles and sticky misalignment flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_stall_cnt <= '0;
            r_misalign  <= 1'b0;
        end else begin
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            r_misalign <= r_misalign | (w_next_state == FAULT);
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of sequencing, redirects, stalls, reset and alignment handling
module tb_pc_sequencer;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        I_BUSYWAIT = 1'b0;
    logic        D_BUSYWAIT = 1'b0;
    logic        JUMP = 1'b0;
    logic        BRANCH = 1'b0;
    logic        ZERO = 1'b0;
    logic [31:0] OFFSET = 32'd0;
    logic [31:0] PC;
    logic        FETCH_VALID;
    logic [3:0]  STALL_CNT;
    logic        MISALIGN;
    int          n_pass = 0;
    int          n_total = 0;

    pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .CNT_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .I_BUSYWAIT(I_BUSYWAIT), .D_BUSYWAIT(D_BUSYWAIT),
        .JUMP(JUMP), .BRANCH(BRANCH), .ZERO(ZERO), .OFFSET(OFFSET),
        .PC(PC), .FETCH_VALID(FETCH_VALID), .STALL_CNT(STALL_CNT), .MISALIGN(MISALIGN)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle();
        I_BUSYWAIT = 0; D_BUSYWAIT = 0; JUMP = 0; BRANCH = 0; ZERO = 0; OFFSET = 0;
    endtask

    task automatic go_pc8();
        idle();
        RESET = 1; tick();
        RESET = 0; tick(); tick();
    endtask

    initial begin
        tick();
        chk("rst_pc", PC, 32'h0);
        chk("rst_cnt", 32'(STALL_CNT), 32'd0);
        chk("rst_mis", 32'(MISALIGN), 32'd0);
        chk("rst_fv", 32'(FETCH_VALID), 32'd0);
        RESET = 0; #1;
        chk("run_fv", 32'(FETCH_VALID), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq_pc", PC, 32'(4 * i));
        end

        go_pc8();
        chk("pc8", PC, 32'h8);
        BRANCH = 1; ZERO = 1; OFFSET = 32'h10; tick();
        chk("beq_taken", PC, 32'h1C);
        go_pc8();
        BRANCH = 1; ZERO = 0; OFFSET = 32'h10; tick();
        chk("beq_not", PC, 32'hC);

        go_pc8();
        JUMP = 1; OFFSET = 32'h20; I_BUSYWAIT = 1; #1;
        chk("stall_fv", 32'(FETCH_VALID), 32'd0);
        tick();
        chk("stall_pc1", PC, 32'h8);
        JUMP = 0; OFFSET = 0; tick();
        chk("stall_pc2", PC, 32'h8);
        tick();
        chk("stall_pc3", PC, 32'h8);
        I_BUSYWAIT = 0; #1;
        chk("stall_cnt3", 32'(STALL_CNT), 32'd3);
        chk("release_fv", 32'(FETCH_VALID), 32'd0);
        tick();
        chk("pend_pc", PC, 32'h2C);
        chk("after_fv", 32'(FETCH_VALID), 32'd1);
        D_BUSYWAIT = 1; tick();
        chk("dstall_pc", PC, 32'h2C);
        D_BUSYWAIT = 0; tick();
        chk("drel_pc", PC, 32'h30);
        chk("dstall_cnt", 32'(STALL_CNT), 32'd4);

        JUMP = 1; OFFSET = 32'hFFFF_FFC4; tick();
        chk("jmp_hi", PC, 32'hFFFF_FFF8);
        OFFSET = 32'h4; tick();
        chk("wrap", PC, 32'h0);
        BRANCH = 1; ZERO = 0; OFFSET = 32'h8; tick();
        chk("jmp_br", PC, 32'hC);
        idle();

        go_pc8();
        JUMP = 1; OFFSET = 32'h20; I_BUSYWAIT = 1; tick();
        JUMP = 0; OFFSET = 0; RESET = 1; tick();
        chk("rst_stall_pc", PC, 32'h0);
        chk("rst_stall_cnt", 32'(STALL_CNT), 32'd0);
        RESET = 0; I_BUSYWAIT = 0; tick();
        chk("no_redirect", PC, 32'h4);

        go_pc8();
        RESET = 1; tick();
        RESET = 0; I_BUSYWAIT = 1;
        for (int i = 0; i < 17; i++) tick();
        chk("sat_cnt", 32'(STALL_CNT), 32'd15);
        chk("sat_pc", PC, 32'h0);
        I_BUSYWAIT = 0; tick();
        chk("sat_rel", PC, 32'h4);

        go_pc8();
        JUMP = 1; OFFSET = 32'h2; tick();
        JUMP = 0; OFFSET = 0;
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_pc", PC, 32'h8);
        chk("mis_flag", 32'(MISALIGN), 32'd1);
        #1 chk("fault_fv", 32'(FETCH_VALID), 32'd0);
        tick(); tick();
        chk("fault_pc", PC, 32'h8);
`else
        chk("mis_pc", PC, 32'hC);
        chk("mis_flag", 32'(MISALIGN), 32'd0);
`endif
        go_pc8();
        JUMP = 1; OFFSET = 32'h2; I_BUSYWAIT = 1; tick();
        JUMP = 0; OFFSET = 0; I_BUSYWAIT = 0; tick();
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_rel_pc", PC, 32'h8);
        chk("mis_rel_flag", 32'(MISALIGN), 32'd1);
`else
        chk("mis_rel_pc", PC, 32'hC);
        chk("mis_rel_flag", 32'(MISALIGN), 32'd0);
`endif
        RESET = 1; tick();
        RESET = 0; tick();
        chk("final_pc", PC, 32'h4);
        chk("final_mis", 32'(MISALIGN), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
